// File: rtl/melody_player.sv
// rtl/melody_player.sv - score-driven square-wave melody player
// Steps through a packed score of {note, dur} entries, toning each note then a silent gap.
module melody_player #(
  parameter int N_STEPS     = 32,
  parameter int STEP_W      = 5,
  parameter int UNIT_CYC    = 5_000_000,
  parameter int GAP_CYC     = 250_000,
  parameter int TABLE_SHIFT = 0,
  parameter logic [N_STEPS*8-1:0] SCORE = {{(N_STEPS*8-48){1'b0}}, 48'h00_37_67_14_C4_57}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic              loop,
  input  logic [1:0]        octave,
  output logic              melody,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [31:0]       UNIT_LAST = 32'(UNIT_CYC - 1);
  localparam logic [31:0]       GAP_LAST  = 32'(GAP_CYC - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

  logic [2:0]  state;
  logic        play_q;
  logic [21:0] hp;
  logic [21:0] hp_cnt;
  logic [3:0]  dur;
  logic        rest;
  logic [31:0] unit_cnt;
  logic [3:0]  unit_num;
  logic [31:0] gap_cnt;

  logic [7:0]  entry;
  logic [21:0] base;
  logic [21:0] shifted;
  logic [21:0] hp_calc;
  logic        play_last;
  logic        gap_last;
  logic        end_of_song;

  function automatic logic [21:0] note_hp(input logic [3:0] n);
    case (n)
      4'd1:    note_hp = 22'd95_556;
      4'd2:    note_hp = 22'd90_193;
      4'd3:    note_hp = 22'd85_131;
      4'd4:    note_hp = 22'd80_353;
      4'd5:    note_hp = 22'd75_843;
      4'd6:    note_hp = 22'd71_587;
      4'd7:    note_hp = 22'd67_568;
      4'd8:    note_hp = 22'd63_776;
      4'd9:    note_hp = 22'd60_196;
      4'd10:   note_hp = 22'd56_818;
      4'd11:   note_hp = 22'd53_629;
      4'd12:   note_hp = 22'd50_619;
      default: note_hp = 22'd0;
    endcase
  endfunction

  assign entry = SCORE[{step, 3'b000} +: 8];

  always_comb begin
    base = note_hp(entry[7:4]) >> TABLE_SHIFT;
    case (octave)
      2'd0:    shifted = base << 1;
      2'd1:    shifted = base;
      2'd2:    shifted = base >> 1;
      default: shifted = base >> 2;
    endcase
    hp_calc = (shifted == 22'd0) ? 22'd1 : shifted;
  end

  assign play_last   = (unit_cnt == UNIT_LAST) && (unit_num == dur - 4'd1);
  assign gap_last    = (gap_cnt == GAP_LAST);
  // A zero-duration entry and the gap after the final entry both end the song.
  assign end_of_song = ((state == S_LOAD) && (entry[3:0] == 4'd0)) ||
                       ((state == S_GAP) && gap_last && (step == LAST_STEP));

  assign busy = (state == S_LOAD) || (state == S_PLAY) || (state == S_GAP);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      play_q   <= 1'b0;
      melody   <= 1'b0;
      step     <= '0;
      hp       <= '0;
      hp_cnt   <= '0;
      dur      <= '0;
      rest     <= 1'b0;
      unit_cnt <= '0;
      unit_num <= '0;
      gap_cnt  <= '0;
    end else begin
      play_q <= play;
      if ((state != S_IDLE) && !play) begin
        state    <= S_IDLE;
        melody   <= 1'b0;
        step     <= '0;
        hp_cnt   <= '0;
        unit_cnt <= '0;
        unit_num <= '0;
        gap_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            step <= '0;
            if (play && !play_q) state <= S_LOAD;
          end
          S_LOAD: begin
            hp       <= hp_calc;
            dur      <= entry[3:0];
            rest     <= (entry[7:4] == 4'd0) || (entry[7:4] > 4'd12);
            hp_cnt   <= '0;
            unit_cnt <= '0;
            unit_num <= '0;
            gap_cnt  <= '0;
            melody   <= 1'b0;
            if (end_of_song) begin
              if (loop) step <= '0;
              state <= loop ? S_LOAD : S_DONE;
            end else begin
              state <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (unit_cnt == UNIT_LAST) begin
              unit_cnt <= '0;
              unit_num <= unit_num + 4'd1;
            end else begin
              unit_cnt <= unit_cnt + 32'd1;
            end
            if (play_last) begin
              state  <= S_GAP;
              melody <= 1'b0;
            end else if (hp_cnt == hp - 22'd1) begin
              hp_cnt <= '0;
              if (!rest) melody <= ~melody;
            end else begin
              hp_cnt <= hp_cnt + 22'd1;
            end
          end
          S_GAP: begin
            if (gap_last) begin
              gap_cnt <= '0;
              if (end_of_song) begin
                if (loop) step <= '0;
                state <= loop ? S_LOAD : S_DONE;
              end else begin
                step  <= step + 1'b1;
                state <= S_LOAD;
              end
            end else begin
              gap_cnt <= gap_cnt + 32'd1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            step  <= '0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
